// File: rtl/lcd_ctrl_if.sv
`timescale 1ns/1ps
// Host-side register interface of the LCD controller: write strobe/command in,
// status flags out.
interface lcd_ctrl_if;
    logic        lcd_we_i;
    logic [31:0] lcd_cmd_i;
    logic        busy_o;
    logic        full_o;
    logic        ovf_o;

    modport master (
        output lcd_we_i,
        output lcd_cmd_i,
        input  busy_o,
        input  full_o,
        input  ovf_o
    );

    modport slave (
        input  lcd_we_i,
        input  lcd_cmd_i,
        output busy_o,
        output full_o,
        output ovf_o
    );
endinterface

// File: rtl/lcd_ctrl.sv
`timescale 1ns/1ps
// HD44780-style LCD write controller: a 4-entry request FIFO feeding a
// SETUP/PULSE/HOLD/WAIT bus-timing sequencer.
module lcd_ctrl #(
    parameter int SETUP_CYC = 3,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 3,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 80000
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    lcd_ctrl_if.slave  bus,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o
);
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > LONG_CYC) ? MAX_AB : LONG_CYC;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 17) ? $clog2(MAX_CYC) : 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [8:0]         fifo_mem [4];
    logic [1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [2:0]         count_reg, count_next;
    logic               ovf_reg;
    logic               lcd_on_reg;
    logic               lcd_rs_reg;
    logic [7:0]         lcd_data_reg;
    logic               lcd_en_reg;

    logic               fifo_full, fifo_empty;
    logic               pop, push, long_wait;
    logic               unused_cmd_bits;

    assign unused_cmd_bits = ^{bus.lcd_cmd_i[30:10], bus.lcd_cmd_i[8]};

    assign fifo_full  = (count_reg == 3'd4);
    assign fifo_empty = (count_reg == 3'd0);
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign push       = bus.lcd_we_i && (!fifo_full || pop);

    // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
    assign long_wait  = !lcd_rs_reg && (lcd_data_reg[7:2] == 6'd0) &&
                        (lcd_data_reg[1:0] != 2'd0);

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {bus.lcd_cmd_i[9], bus.lcd_cmd_i[7:0]};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            ovf_reg    <= 1'b0;
            lcd_on_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            if (bus.lcd_we_i && !push) begin
                ovf_reg <= 1'b1;
            end
            if (bus.lcd_we_i) begin
                lcd_on_reg <= bus.lcd_cmd_i[31];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                    cnt_next   = CNT_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_PULSE;
                    cnt_next   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_WAIT;
                    cnt_next   = long_wait ? CNT_W'(LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // EN is decoded from the next state and registered so the pin never glitches.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            lcd_en_reg   <= 1'b0;
            lcd_rs_reg   <= 1'b0;
            lcd_data_reg <= 8'h00;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lcd_en_reg <= (state_next == ST_PULSE);
            if (pop) begin
                {lcd_rs_reg, lcd_data_reg} <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    assign lcd_data_o = lcd_data_reg;
    assign lcd_rs_o   = lcd_rs_reg;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = lcd_en_reg;
    assign lcd_on_o   = lcd_on_reg;

    assign bus.busy_o = (state_reg != ST_IDLE) || !fifo_empty;
    assign bus.full_o = fifo_full;
    assign bus.ovf_o  = ovf_reg;
endmodule

// File: tb/tb_lcd_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lcd_ctrl with short timing parameters; every entry issued
// on the LCD bus is captured at the EN rising edge and compared in order.
module tb_lcd_ctrl;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 8;
    localparam int LONG  = 32;
    localparam int T_SHORT = 1 + SETUP + PULSE + HOLD + EXEC;
    localparam int T_LONG  = 1 + SETUP + PULSE + HOLD + LONG;

    logic       clock_i  = 1'b0;
    logic       reset_ni = 1'b0;
    logic [7:0] lcd_data_o;
    logic       lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;

    lcd_ctrl_if bus();

    lcd_ctrl #(
        .SETUP_CYC (SETUP),
        .PULSE_CYC (PULSE),
        .HOLD_CYC  (HOLD),
        .EXEC_CYC  (EXEC),
        .LONG_CYC  (LONG)
    ) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .bus        (bus),
        .lcd_data_o (lcd_data_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_on_o   (lcd_on_o)
    );

    always #5 clock_i = ~clock_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] mon_q[$];
    logic       en_prev  = 1'b0;

    always @(negedge clock_i) begin
        if (lcd_en_o && !en_prev) begin
            mon_q.push_back({lcd_rs_o, lcd_data_o});
        end
        en_prev = lcd_en_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock_i);
    endtask

    task automatic push(input logic [31:0] cmd);
        bus.lcd_we_i  = 1'b1;
        bus.lcd_cmd_i = cmd;
        step();
        bus.lcd_we_i  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy_o && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic run_one(input logic [31:0] cmd, input int exp_len, input string tag);
        int n;
        push(cmd);
        wait_idle(n);
        $display("txn %s cmd=%08h busy_cycles=%0d", tag, cmd, n);
        chk({tag, "_len"}, n, exp_len);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        step();
        step();
        reset_ni = 1'b1;
        mon_q.delete();
    endtask

    task automatic chk_queue(input string tag, input logic [8:0] exp[$]);
        chk({tag, "_count"}, mon_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < mon_q.size()) begin
                chk($sformatf("%s_entry%0d", tag, i), mon_q[i], exp[i]);
            end
        end
    endtask

    initial begin
        int         n;
        logic [8:0] exp_q[$];

        bus.lcd_we_i  = 1'b0;
        bus.lcd_cmd_i = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_en", lcd_en_o, 0);
        chk("rst_rs", lcd_rs_o, 0);
        chk("rst_rw", lcd_rw_o, 0);
        chk("rst_on", lcd_on_o, 0);
        chk("rst_data", lcd_data_o, 8'h00);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_full", bus.full_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
        reset_ni = 1'b1;
        step();

        // Single data write: cycle-accurate EN and busy profile
        bus.lcd_we_i  = 1'b1;
        bus.lcd_cmd_i = 32'h8000_0241;
        step();
        bus.lcd_we_i  = 1'b0;
        $display("txn data_41 cmd=80000241");
        chk("on_after_push", lcd_on_o, 1);
        for (int e = 0; e <= 18; e++) begin
            chk($sformatf("en@%0d", e), lcd_en_o, (e >= 3 && e <= 6));
            chk($sformatf("busy@%0d", e), bus.busy_o, (e < 17));
            if (e == 1) begin
                chk("pop_rs", lcd_rs_o, 1);
                chk("pop_data", lcd_data_o, 8'h41);
            end
            step();
        end
        chk("rw_tied", lcd_rw_o, 0);

        // Long vs normal execution waits
        mon_q.delete();
        run_one(32'h0000_0001, T_LONG, "clear");
        chk("on_cleared", lcd_on_o, 0);
        run_one(32'h0000_0038, T_SHORT, "func_set");
        run_one(32'h0000_0203, T_SHORT, "data_03");
        run_one(32'h0000_0003, T_LONG, "home_03");
        run_one(32'h0000_0004, T_SHORT, "mode_04");
        run_one(32'h0000_0002, T_LONG, "home_02");
        exp_q = '{9'h001, 9'h038, 9'h103, 9'h003, 9'h004, 9'h002};
        chk_queue("waits", exp_q);

        // Overflow: five pushes while busy, fifth dropped
        mon_q.delete();
        push(32'h0000_0010);
        step();
        for (int i = 0; i < 5; i++) begin
            push(32'h0000_0011 + i);
            $display("txn burst push=%02h full=%0b ovf=%0b", 8'h11 + i, bus.full_o, bus.ovf_o);
            if (i == 2) chk("burst_full_3", bus.full_o, 0);
            if (i == 3) begin
                chk("burst_full_4", bus.full_o, 1);
                chk("burst_ovf_4", bus.ovf_o, 0);
            end
            if (i == 4) begin
                chk("burst_full_5", bus.full_o, 1);
                chk("burst_ovf_5", bus.ovf_o, 1);
            end
        end
        wait_idle(n);
        chk("burst_drained", bus.busy_o, 0);
        chk("ovf_sticky", bus.ovf_o, 1);
        chk("burst_full_clear", bus.full_o, 0);
        exp_q = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014};
        chk_queue("burst", exp_q);

        do_reset();
        chk("ovf_reset", bus.ovf_o, 0);

        // Push into a full FIFO on the same edge as the IDLE pop
        push(32'h0000_0020);
        step();
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_0021 + i);
        end
        chk("coinc_full_pre", bus.full_o, 1);
        repeat (12) step();
        chk("coinc_full_e17", bus.full_o, 1);
        chk("coinc_data_e17", lcd_data_o, 8'h20);
        push(32'h0000_0025);
        $display("txn coincident push=25 full=%0b ovf=%0b", bus.full_o, bus.ovf_o);
        chk("coinc_full_e18", bus.full_o, 1);
        chk("coinc_ovf_e18", bus.ovf_o, 0);
        chk("coinc_pop_data", lcd_data_o, 8'h21);
        wait_idle(n);
        exp_q = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h025};
        chk_queue("coinc", exp_q);

        // Asynchronous reset during PULSE
        push(32'h8000_0233);
        push(32'h0000_0234);
        repeat (3) step();
        chk("mid_pulse_en", lcd_en_o, 1);
        #2 reset_ni = 1'b0;
        #1;
        $display("txn async_reset mid-pulse");
        chk("arst_en", lcd_en_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_full", bus.full_o, 0);
        chk("arst_rs", lcd_rs_o, 0);
        chk("arst_data", lcd_data_o, 8'h00);
        chk("arst_on", lcd_on_o, 0);
        step();
        reset_ni = 1'b1;
        mon_q.delete();
        step();
        run_one(32'h0000_0255, T_SHORT, "post_reset");
        exp_q = '{9'h155};
        chk_queue("post_reset", exp_q);

        // Pointer wrap: eight pushes in pairs with drains between
        do_reset();
        exp_q = {};
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_02A0 + 2 * i);
            push(32'h0000_00A1 + 2 * i);
            $display("txn wrap pair=%0d", i);
            wait_idle(n);
            exp_q.push_back(9'h1A0 + 9'(2 * i));
            exp_q.push_back(9'h0A1 + 9'(2 * i));
        end
        chk_queue("wrap", exp_q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The parameter SETUP_CYC SHALL default to 3 and set the number of cycles RS and DATA are stable before EN rises.
REQ-002 The parameter PULSE_CYC SHALL default to 25 and set the number of cycles EN is held high.
REQ-003 The parameter HOLD_CYC SHALL default to 3 and set the number of cycles RS and DATA are held after EN falls.
REQ-004 The parameter EXEC_CYC SHALL default to 2000 and set the post-hold wait for a normal command or data write.
REQ-005 The parameter LONG_CYC SHALL default to 80000 and set the post-hold wait for clear and home commands.
REQ-006 The module SHALL have one clock and an asynchronous active-low reset, with ports named clock_i and reset_ni.
REQ-007 The port clock_i SHALL be an input of width 1 and serve as the system clock; all state updates on its rising edge.
REQ-008 The port reset_ni SHALL be an input of width 1 and serve as the asynchronous active-low reset.
REQ-009 The port lcd_we_i SHALL be an input of width 1 and act as a one-cycle write strobe from the load/store unit LCD register.
REQ-010 The port lcd_cmd_i SHALL be an input of width 32 with these fields: [31] display power, [9] RS, [7:0] data byte; all other bits are ignored.
REQ-011 The port lcd_data_o SHALL be an output of width 8 and drive the LCD data bus.
REQ-012 The port lcd_rs_o SHALL be an output of width 1 and drive LCD register select (0 = command, 1 = data).
REQ-013 The port lcd_rw_o SHALL be an output of width 1 and SHALL be tied to 0, because the block is write-only.
REQ-014 The port lcd_en_o SHALL be an output of width 1 and drive the LCD enable strobe.
REQ-015 The port lcd_on_o SHALL be an output of width 1 and drive LCD power/backlight.
REQ-016 The port busy_o SHALL be an output of width 1 and be high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-017 The port full_o SHALL be an output of width 1 and be high when the FIFO holds 4 entries.
REQ-018 The port ovf_o SHALL be an output of width 1 and act as a sticky flag marking a write dropped because the FIFO was full.

Function
REQ-019 The request FIFO SHALL be 4 entries deep and 9 bits wide ({RS, data}), with 2-bit read/write pointers that wrap 3 -> 0 and a 3-bit occupancy count.
REQ-020 lcd_we_i high at a rising edge SHALL push {lcd_cmd_i[9], lcd_cmd_i[7:0]} if the FIFO is not full.
REQ-021 A push to a full FIFO SHALL be discarded, SHALL set ovf_o, and SHALL leave the FIFO contents unchanged.
REQ-022 A simultaneous push and pop on a full FIFO SHALL accept the push, and the occupancy SHALL stay at 4.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL NOT bypass the FIFO; the pushed entry is popped on a later cycle.
REQ-024 lcd_on_o SHALL take lcd_cmd_i[31] on every lcd_we_i edge, including edges whose push is dropped, and SHALL NOT be queued.
REQ-025 The FSM states SHALL be IDLE, SETUP, PULSE, HOLD and WAIT.
REQ-026 In IDLE with a non-empty FIFO, the FSM SHALL pop the head entry, register it onto lcd_rs_o and lcd_data_o, and enter SETUP on the same edge.
REQ-027 SETUP SHALL last SETUP_CYC cycles with EN=0, then the FSM SHALL enter PULSE.
REQ-028 PULSE SHALL last PULSE_CYC cycles with EN=1, then the FSM SHALL enter HOLD.
REQ-029 HOLD SHALL last HOLD_CYC cycles with EN=0, then the FSM SHALL enter WAIT.
REQ-030 WAIT SHALL last LONG_CYC cycles when the entry has RS=0 and data is 0x01, 0x02 or 0x03, and EXEC_CYC cycles otherwise; the FSM then enters IDLE.
REQ-031 lcd_rs_o and lcd_data_o SHALL remain constant from SETUP entry until the next pop.
REQ-032 lcd_en_o SHALL be a registered output and SHALL be glitch-free.
REQ-033 The phase counter SHALL be at least 17 bits wide, SHALL load (N-1) on each state entry, and SHALL count down to 0.
REQ-034 A phase of 0 cycles is illegal, and all parameters SHALL be at least 1.
REQ-035 Latency: for a push at edge k into an empty FIFO with the FSM in IDLE, the pop SHALL occur at edge k+1 and EN SHALL rise at edge k+1+SETUP_CYC.
REQ-036 The total occupancy per entry SHALL be 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles, measured from pop-eligibility to return to IDLE.
REQ-037 Back-to-back FIFO entries SHALL be issued with no extra idle cycles beyond the IDLE pop cycle.
REQ-038 ovf_o SHALL clear only on reset.

Reset
REQ-039 Assertion of reset_ni SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, empty the FIFO, and clear ovf_o.
REQ-040 Assertion of reset_ni SHALL immediately drive lcd_en_o, lcd_rs_o, lcd_on_o and lcd_rw_o to 0, lcd_data_o to 0x00, busy_o to 0 and full_o to 0.
REQ-041 A reset during PULSE SHALL drop EN in the same cycle, and the in-flight entry SHALL be lost.
REQ-042 Operation SHALL resume on the first rising edge after reset_ni deasserts.

Verification (SETUP_CYC=2, PULSE_CYC=4, HOLD_CYC=2, EXEC_CYC=8, LONG_CYC=32)
REQ-043 Push 0x8000_0241 at edge 0 -> lcd_on_o=1 and pop at edge 1 with RS=1, data 0x41; EN is high during edges 3-6; busy_o falls at edge 17.
REQ-044 Push RS=0 with data 0x01 -> WAIT lasts 32 cycles; then push 0x38 -> WAIT lasts 8 cycles.
REQ-045 Five pushes on consecutive cycles while the FSM is busy -> full_o=1 after the fourth push is stored, the fifth push is dropped, ovf_o=1, and the first four bytes appear on lcd_data_o in order.
REQ-046 A push while full in the same cycle as an IDLE pop -> the push is accepted, full_o stays 1, and ovf_o stays 0.
REQ-047 reset_ni pulled low mid-PULSE -> lcd_en_o falls without a clock edge, busy_o=0, the FIFO is empty, and the next push after release starts a fresh sequence.
REQ-048 Eight pushes with drains in between so the pointers wrap twice -> the bytes emerge in order with no loss or duplication.
